bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
//   Sits between the Fibonacci core and the seven-segment display mux:
//   takes the Fibonacci result on a start pulse and returns DIGITS packed BCD digits.
//   The result is held in a separate output register, so the display
//   never shows intermediate values.
// PARAMETERS
//   BIN_W   32  width of binary input; also the number of shift iterations
//   DIGITS  8   number of BCD digits produced (4*DIGITS output bits)
// PORTS
//   clk        in   1           system clock, all logic on rising edge
//   rst        in   1           synchronous reset, active-high
//   start      in   1           request conversion; sampled only when ready=1
//   bin        in   BIN_W       binary value; captured on accepted start
//   ready      out  1           1 = idle, start will be accepted
//   done_tick  out  1           one-cycle pulse: bcd/ovf updated this cycle
//   bcd        out  4*DIGITS    packed result; digit 0 (LSD) at [3:0]
//   ovf        out  1           1 = value exceeded 10^DIGITS-1 (bcd truncated)
//   blank      out  DIGITS      only with BIN2BCD_BLANK_EN (see CONFIGURATION)
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset: state=IDLE; ready=1; done_tick=0; bcd=0; ovf=0; blank=0;
//     working registers cleared. Reset wins over a same-cycle start.
//   FSM states: IDLE, OP, DONE.
//     IDLE: ready=1. On start=1: load bin into shift reg, clear work BCD reg
//       and the sticky ovf, load iteration counter with BIN_W, go to OP.
//     OP: ready=0. Each cycle, in order: every work digit >=5 gets +3 (4-bit);
//       then shift {work_bcd, shift_reg} left by 1. If the bit shifted out
//       of the top digit is 1, set sticky ovf. Decrement counter; after the
//       BIN_W-th shift go to DONE.
//     DONE: copy work_bcd->bcd and sticky ovf->ovf; done_tick=1 for exactly
//       this cycle; next state IDLE.
//   Latency: start accepted at edge k -> done_tick high in the cycle after
//     edge k+BIN_W+1 (BIN_W+1 cycles from accept); bcd valid from the same cycle.
//   bcd/ovf hold their values until the next DONE. They are unchanged during OP.
//   start while ready=0 is ignored (no queueing). start held high across DONE
//     starts a new conversion at the first IDLE cycle.
//   Overflow: bcd = value mod 10^DIGITS; ovf=1 iff value >= 10^DIGITS.
//   Reset during OP: the conversion is aborted with no done_tick. Outputs go to
//     their reset values.
//   bin is sampled only at accept. Later changes to bin do not affect the result.
// CONFIGURATION
//   BIN2BCD_BLANK_EN defined: registered output blank[DIGITS-1:0], updated
//     with bcd in DONE. blank[i]=1 iff digit i and all digits above it are 0,
//     for i>=1. blank[0] is always 0, so value 0 shows a single "0".
//   Not defined: the blank port and its logic do not exist. The display
//     shows leading zeros.
// TESTING (BIN_W=32, DIGITS=8, 100 MHz clk)
//   1. bin=24157817 (fib(37)), start 1 cycle -> done_tick 33 cycles after
//      accept, bcd=32'h24157817, ovf=0, ready back to 1 next cycle.
//   2. bin=0 -> bcd=32'h00000000, ovf=0.
//      With BIN2BCD_BLANK_EN: blank=8'b11111110.
//   3. bin=99999999 -> bcd=32'h99999999, ovf=0.
//      bin=100000000 -> bcd=32'h00000000, ovf=1.
//   4. Accept bin=55. Mid-OP pulse start with bin=89 -> ignored. bcd=32'h00000055
//      and exactly one done_tick. With BIN2BCD_BLANK_EN: blank=8'b11111100.
//   5. Complete 55. Start 89, assert rst for 1 cycle at iteration 10 ->
//      no done_tick, bcd=0, ready=1. A new start with bin=144 gives bcd=32'h00000144.
//   6. rst and start in the same cycle -> stays IDLE, no conversion.
//      start held high for 80 cycles with bin=21 -> back-to-back conversions,
//      done_tick every 34 cycles, bcd=32'h00000021 each time.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with sticky overflow.
// Optional leading-zero blanking output when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

    state_t           state, next;
    logic [BIN_W-1:0] shreg;
    logic [W-1:0]     work, adj;
    logic [CW-1:0]    cnt;
    logic             sticky;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next;
    end

    always_comb begin
        next  = state;
        ready = state == IDLE;
        next  = (state == IDLE) ? (start ? OP : IDLE) :
                (state == OP)   ? (cnt == CW'(1) ? DONE : OP) : IDLE;
    end

    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = (work[4*i+:4] >= 4'd5) ? work[4*i+:4] + 4'd3 : work[4*i+:4];
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_n;
    logic              z;

    // blank[0] is never set so a zero value still shows one digit
    always_comb begin
        blank_n = '0;
        z       = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z          = z & (work[4*i+:4] == 4'd0);
            blank_n[i] = z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            blank <= '0;
        else if (state == DONE)
            blank <= blank_n;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            work      <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            done_tick <= state == DONE;
            if (state == IDLE && start) begin
                shreg  <= bin;
                work   <= '0;
                sticky <= 1'b0;
                cnt    <= CW'(BIN_W);
            end else if (state == OP) begin
                // a 1 leaving the top digit means the value reached 10^DIGITS
                work   <= {adj[W-2:0], shreg[BIN_W-1]};
                shreg  <= {shreg[BIN_W-2:0], 1'b0};
                sticky <= sticky | adj[W-1];
                cnt    <= cnt - CW'(1);
            end else if (state == DONE) begin
                bcd <= work;
                ovf <= sticky;
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of bin2bcd_seq latency, values, overflow, abort and back-to-back.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bin = '0;
    logic        ready, done_tick, ovf;
    logic [31:0] bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [7:0]  blank;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(32), .DIGITS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .ready(ready), .done_tick(done_tick), .bcd(bcd), .ovf(ovf)
`ifdef BIN2BCD_BLANK_EN
        , .blank(blank)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic convert(input logic [31:0] v, output int cyc);
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        bin = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin = 32'hFFFF_FFFF;
        cyc = 0;
        while (!done_tick && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic count_ticks(input int n, output int t);
        t = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (done_tick) t++;
        end
    endtask

    initial begin
        int cyc, t, last;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done_tick, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        convert(32'd24157817, cyc);
        chk("fib37_latency", cyc, 33);
        chk("fib37_bcd", bcd, 32'h24157817);
        chk("fib37_ovf", ovf, 0);
        chk("fib37_ready", ready, 1);
`ifdef BIN2BCD_BLANK_EN
        chk("fib37_blank", blank, 8'b00000000);
`endif
        @(negedge clk);
        chk("fib37_pulse_one", done_tick, 0);
        chk("fib37_ready_next", ready, 1);

        convert(32'd0, cyc);
        chk("zero_latency", cyc, 33);
        chk("zero_bcd", bcd, 32'h0);
        chk("zero_ovf", ovf, 0);
`ifdef BIN2BCD_BLANK_EN
        chk("zero_blank", blank, 8'b11111110);
`endif

        convert(32'd99999999, cyc);
        chk("max_bcd", bcd, 32'h99999999);
        chk("max_ovf", ovf, 0);
        convert(32'd100000000, cyc);
        chk("ovf_bcd", bcd, 32'h0);
        chk("ovf_flag", ovf, 1);

        @(negedge clk);
        bin = 32'd55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("op_ready_low", ready, 0);
        chk("op_bcd_hold", bcd, 32'h0);
        chk("op_ovf_hold", ovf, 1);
        bin = 32'd89;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done_tick && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignore_latency", cyc, 27);
        chk("ignore_bcd", bcd, 32'h55);
        chk("ignore_ovf", ovf, 0);
`ifdef BIN2BCD_BLANK_EN
        chk("ignore_blank", blank, 8'b11111100);
`endif
        count_ticks(40, t);
        chk("ignore_one_tick", t, 0);

        @(negedge clk);
        bin = 32'd89;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_bcd", bcd, 32'h0);
        chk("abort_ready", ready, 1);
        chk("abort_done", done_tick, 0);
        count_ticks(40, t);
        chk("abort_no_tick", t, 0);
        convert(32'd144, cyc);
        chk("after_abort_bcd", bcd, 32'h144);

        @(negedge clk);
        bin = 32'd21;
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_ready", ready, 1);
        chk("rst_start_bcd", bcd, 32'h0);
        count_ticks(40, t);
        chk("rst_start_no_tick", t, 0);

        @(negedge clk);
        start = 1'b1;
        t = 0;
        last = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (done_tick) begin
                t++;
                chk("b2b_bcd", bcd, 32'h21);
                if (t > 1) chk("b2b_period", c - last, 34);
                last = c;
            end
        end
        start = 1'b0;
        chk("b2b_tick_count", t, 2);
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
